// File: rtl/buffer_arbiter_pkg.sv
// Shared widths, defaults and lock-state encoding for the buffer arbiter slice.
package buffer_arb_pkg;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_DATA_W    = 1;
    localparam int DEF_BURST_MAX = 4;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } lock_state_e;

    function automatic int src_width(input int num_req);
        return (num_req <= 2) ? 1 : $clog2(num_req);
    endfunction

    // Burst counter must be able to hold BURST_MAX itself.
    function automatic int cnt_width(input int burst_max);
        return (burst_max <= 1) ? 1 : $clog2(burst_max + 1);
    endfunction

endpackage

// File: rtl/buffer_arbiter_if.sv
// Requester/downstream bundle of the buffer arbiter; slave is the arbiter side.
interface buffer_arbiter_if
    import buffer_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DATA_W  = DEF_DATA_W
);
    localparam int SRC_W = src_width(NUM_REQ);

    logic                      enable;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        gnt;
    logic                      out_valid;
    logic [DATA_W-1:0]         out_data;
    logic [SRC_W-1:0]          out_src;
    logic                      out_ready;
    logic                      locked;

    modport master (
        output enable, req, req_data, out_ready,
        input  gnt, out_valid, out_data, out_src, locked
    );

    modport slave (
        input  enable, req, req_data, out_ready,
        output gnt, out_valid, out_data, out_src, locked
    );

endinterface

// File: rtl/buffer_arbiter_rr_pick.sv
// Combinational round-robin picker: first active request at or after start, wrapping.
module rr_pick
    import buffer_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int SRC_W   = src_width(DEF_NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [SRC_W-1:0]   start,
    output logic [NUM_REQ-1:0] onehot,
    output logic               found
);

    int idx;

    always_comb begin
        onehot = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(start) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                onehot[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/buffer_arbiter.sv
// Round-robin arbiter with bounded burst lock feeding one registered output stage.
// state      | meaning
// ARB_IDLE   | no owner; next scan starts at ptr
// ARB_LOCKED | owner holds the stage until it drops req or reaches BURST_MAX
module buffer_arbiter
    import buffer_arb_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int BURST_MAX = DEF_BURST_MAX
) (
    input  logic         clk,
    input  logic         rst_n,
    buffer_arbiter_if.slave bus
);

    localparam int SRC_W = src_width(NUM_REQ);
    localparam int CNT_W = cnt_width(BURST_MAX);
    localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(BURST_MAX);
    localparam logic [SRC_W-1:0] LAST_IDX  = SRC_W'(NUM_REQ - 1);

    function automatic logic [SRC_W-1:0] wrap_inc(input logic [SRC_W-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + 1'b1;
    endfunction

    lock_state_e        state_q, state_d;
    logic [SRC_W-1:0]   owner_q, owner_d;
    logic [SRC_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   burst_q, burst_d;
    logic               out_valid_q, out_valid_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;
    logic [SRC_W-1:0]   out_src_q, out_src_d;

    logic               accept;
    logic               hold_owner;
    logic [SRC_W-1:0]   start_idx;
    logic [NUM_REQ-1:0] pick_oh;
    logic               pick_found;
    logic [NUM_REQ-1:0] gnt_c;
    logic [SRC_W-1:0]   gnt_idx;
    logic               xfer;
    logic [CNT_W-1:0]   burst_nx;

    always_comb begin
        accept     = !out_valid_q || bus.out_ready;
        hold_owner = (state_q == ARB_LOCKED) && bus.req[owner_q] && (burst_q < BURST_LIM);
        start_idx  = (state_q == ARB_LOCKED) ? wrap_inc(owner_q) : ptr_q;
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .SRC_W   (SRC_W)
    ) u_pick (
        .req    (bus.req),
        .start  (start_idx),
        .onehot (pick_oh),
        .found  (pick_found)
    );

    // Reset gates the grant so nothing is offered while rst_n is low.
    always_comb begin
        gnt_c = '0;
        if (rst_n && bus.enable && accept) begin
            if (hold_owner) begin
                gnt_c = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q;
            end else if (pick_found) begin
                gnt_c = pick_oh;
            end
        end
        gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_c[i]) gnt_idx = SRC_W'(i);
        end
        xfer = |gnt_c;
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        burst_d     = burst_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        burst_nx    = burst_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = bus.req_data[int'(gnt_idx)*DATA_W +: DATA_W];
            out_src_d   = gnt_idx;
            if (state_q == ARB_LOCKED && gnt_idx == owner_q) begin
                burst_nx = burst_q + 1'b1;
            end else begin
                burst_nx = CNT_W'(1);
                owner_d  = gnt_idx;
            end
            burst_d = burst_nx;
            state_d = ARB_LOCKED;
            if (burst_nx == BURST_LIM) begin
                state_d = ARB_IDLE;
                ptr_d   = wrap_inc(gnt_idx);
            end
        end else begin
            if (bus.out_ready) out_valid_d = 1'b0;
            // Release only counts while grants are possible; stall and disable hold the lock.
            if (state_q == ARB_LOCKED && bus.enable && accept && !bus.req[owner_q]) begin
                state_d = ARB_IDLE;
                ptr_d   = wrap_inc(owner_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB_IDLE;
            owner_q     <= '0;
            ptr_q       <= '0;
            burst_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            burst_q     <= burst_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

    assign bus.gnt       = gnt_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;
    assign bus.locked    = (state_q == ARB_LOCKED);

endmodule
